frame_pipe_ctrl: RTL and testbench
==================================

# frame_pipe_ctrl

Frame-gating controller and valid/marker tracker for a fixed-latency, free-running pixel datapath built from `delay` stages with no clock enable. It admits whole frames only, starting on a start-of-frame beat while enabled, and carries valid/SOF/EOL/EOF tokens through a LATENCY-deep token pipe so they leave aligned with the datapath output. It tracks in-flight beats, sequences IDLE/RUN/DRAIN, and reports frame completion and protocol errors to the background-model top level.

## Interface
- LATENCY, 4, datapath latency in cycles; must be at least 1 and equal the DELAY of the controlled datapath.
- CNT_W, 16, width of the statistics counters.
- IW, derived as clog2(LATENCY+1), width of `inflight`.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level request to process frames; sampled only at frame start.
- in_valid  in  1  input beat valid.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_eol  in  1  end of line; qualified by in_valid.
- in_eof  in  1  end of frame; qualified by in_valid.
- accept  out  1  combinational; the current input beat is admitted into the datapath.
- out_valid  out  1  output beat valid, aligned with the datapath q.
- out_sof, out_eol, out_eof  out  1 each  output markers; always 0 when out_valid=0.
- busy  out  1  state is not IDLE.
- inflight  out  IW  number of admitted beats still in the token pipe.
- frame_done  out  1  one-cycle pulse, equal to out_valid & out_eof.
- err_sof  out  1  sticky; set by an in_sof received while in RUN.
- frame_cnt  out  CNT_W  completed frames (see Configuration).
- line_cnt  out  CNT_W  lines output in the current or last frame (see Configuration).

## Operation
- States are IDLE, RUN and DRAIN. Encoding is free.
- Admission rule:
  - In IDLE or DRAIN: accept = en & in_valid & in_sof.
  - In RUN: accept = in_valid.
- Transitions:
  - IDLE or DRAIN -> RUN on accept & ~in_eof.
  - IDLE or DRAIN -> DRAIN on accept & in_eof (one-beat frame).
  - RUN -> DRAIN on accept & in_eof. in_eof has priority over everything else.
  - DRAIN -> IDLE when no beat is accepted and the pipe empties this cycle: inflight==1 with out_valid=1, or inflight==0.
- Token pipe: LATENCY stages, each holding {v, sof, eol, eof}. The stage 0 input is {accept, accept&in_sof, accept&in_eol, accept&in_eof}. Outputs come from the last stage.
- inflight update: next = inflight + accept - out_valid. It never exceeds LATENCY.
- err_sof:
  - Set on in_valid & in_sof in RUN. The beat is still accepted and its SOF marker is passed through.
  - Cleared only by reset.
- en is ignored inside a frame. Dropping en in RUN still completes the frame.
- Beats not accepted are dropped: their tokens are zero, and the datapath output for them must be ignored downstream.

## Timing
- Input to output latency is exactly LATENCY cycles.
- accept is combinational from the inputs and state. No other output has a combinational input path.
- A frame back-to-back with the previous one is allowed: an SOF beat during DRAIN is admitted in that same cycle, with no bubble.
- Reset value of every registered output is 0, and state is IDLE.
- Asserting rst_n mid-frame immediately clears all tokens and counters. The next accepted frame needs a fresh SOF.

## Configuration
- FRAME_STATS_EN defined:
  - frame_cnt increments on frame_done and wraps at 2^CNT_W.
  - line_cnt loads (out_eol?1:0) on out_valid&out_sof. Otherwise it increments on out_valid&out_eol, and holds after the frame.
- FRAME_STATS_EN undefined: frame_cnt and line_cnt are constant 0 and no counter registers are built.

## Test plan
All scenarios use LATENCY=4.
- Idle gating: en=1, in_valid=1, in_sof=0 for 10 cycles -> accept=0, out_valid stays 0, busy=0.
- Single frame:
  - Stimulus: SOF at cycle 0, 8 beats, EOL on beats 3 and 7, EOF on beat 7.
  - Response: out_valid on cycles 4–11; out_sof at 4; out_eol at 7 and 11; frame_done at 11.
  - Busy and inflight: busy drops at cycle 12, inflight is 4 during cycles 4–7, and inflight is 0 at cycle 12.
  - With FRAME_STATS_EN: frame_cnt=1 and line_cnt=2.
- Back-to-back: frame B's SOF arrives the cycle after frame A's EOF -> B's SOF is accepted with state DRAIN->RUN, output is continuous, and two frame_done pulses are LATENCY-separated per each frame's EOF.
- Mid-frame en drop and error:
  - Stimulus: en=0 at beat 2, and in_sof on beat 4.
  - Response: the frame completes, err_sof=1 from beat 4 onward, and the beat-4 token emerges with out_sof=1.
- Reset mid-frame: rst_n=0 at beat 3 -> out_valid, inflight, busy and err_sof become 0 immediately. After release, non-SOF beats are rejected.
- One-beat frame: a beat with SOF+EOL+EOF while IDLE -> IDLE->DRAIN, out beat with all markers 4 cycles later, then IDLE.

Source files
------------

// File: rtl/frame_pipe_ctrl.sv
// Frame-gating controller and valid/marker token pipe for a fixed-latency datapath.
// Define FRAME_STATS_EN to build the frame_cnt / line_cnt statistics counters.
module frame_pipe_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16,
  parameter int IW      = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_eof,
  output logic             accept,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic [IW-1:0]    inflight,
  output logic             frame_done,
  output logic             err_sof,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] line_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Token layout: {valid, sof, eol, eof}
  localparam int TV   = 3;
  localparam int TSOF = 2;
  localparam int TEOL = 1;
  localparam int TEOF = 0;

  state_t          state_q, state_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            err_sof_q, err_sof_d;
  logic [3:0]      tok_in;
  logic [3:0]      pipe_q [LATENCY];
  logic [3:0]      pipe_d [LATENCY];
  logic            pipe_empties;

  assign accept = (state_q == ST_RUN) ? in_valid : (en & in_valid & in_sof);
  assign tok_in = {accept, accept & in_sof, accept & in_eol, accept & in_eof};

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = tok_in;
      end else begin : g_body
        assign pipe_d[gi] = pipe_q[gi-1];
      end
    end
  endgenerate

  assign out_valid  = pipe_q[LATENCY-1][TV];
  assign out_sof    = pipe_q[LATENCY-1][TSOF];
  assign out_eol    = pipe_q[LATENCY-1][TEOL];
  assign out_eof    = pipe_q[LATENCY-1][TEOF];
  assign frame_done = out_valid & out_eof;
  assign busy       = (state_q != ST_IDLE);
  assign inflight   = inflight_q;
  assign err_sof    = err_sof_q;

  // The last in-flight token leaves this cycle (or nothing was left to drain).
  assign pipe_empties = (inflight_q == IW'(0)) ||
                        ((inflight_q == IW'(1)) && out_valid);

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q + IW'(accept) - IW'(out_valid);
    err_sof_d  = err_sof_q;

    case (state_q)
      ST_RUN: begin
        if (in_valid && in_sof) begin
          err_sof_d = 1'b1;
        end
        if (accept && in_eof) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          state_d = in_eof ? ST_DRAIN : ST_RUN;
        end else if (pipe_empties) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (accept) begin
          state_d = in_eof ? ST_DRAIN : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      inflight_q <= '0;
      err_sof_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      err_sof_q  <= err_sof_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

`ifdef FRAME_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    // A new frame restarts the line count; it holds once the frame has left.
    if (out_valid && out_sof) begin
      line_cnt_d = out_eol ? CNT_W'(1) : CNT_W'(0);
    end else if (out_valid && out_eol) begin
      line_cnt_d = line_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign line_cnt  = line_cnt_q;
`else
  assign frame_cnt = '0;
  assign line_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_pipe_ctrl.sv
// Randomized and directed bench for frame_pipe_ctrl against a cycle-history reference model.
module tb_frame_pipe_ctrl;

  localparam int LATENCY = 4;
  localparam int CNT_W   = 16;
  localparam int IW      = $clog2(LATENCY + 1);
  localparam int HIST    = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, in_eof = 1'b0;
  logic accept, out_valid, out_sof, out_eol, out_eof, busy, frame_done, err_sof;
  logic [IW-1:0]    inflight;
  logic [CNT_W-1:0] frame_cnt, line_cnt;

  frame_pipe_ctrl #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
    .in_eol(in_eol), .in_eof(in_eof), .accept(accept), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
    .inflight(inflight), .frame_done(frame_done), .err_sof(err_sof),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the token admitted in every cycle since reset, plus frame state.
  logic [3:0] hist [HIST];
  int  cyc;
  bit  m_in_frame;
  bit  m_err;
  int  m_frame_cnt;
  int  m_line_cnt;

  function automatic logic [3:0] tok_at(input int c);
    return (c >= 0) ? hist[c] : 4'b0000;
  endfunction

  task automatic model_reset();
    cyc         = 0;
    m_in_frame  = 1'b0;
    m_err       = 1'b0;
    m_frame_cnt = 0;
    m_line_cnt  = 0;
  endtask

  // Drive one beat, check all outputs for this cycle mid-period, advance the model.
  task automatic cycle(input bit e, input bit v, input bit s, input bit l, input bit f);
    bit         exp_acc;
    logic [3:0] o;
    int         infl;
    en = e; in_valid = v; in_sof = s; in_eol = l; in_eof = f;
    @(negedge clk);
    exp_acc = m_in_frame ? v : (e & v & s);
    o = tok_at(cyc - LATENCY);
    infl = 0;
    for (int k = 1; k <= LATENCY; k++) infl += int'(tok_at(cyc - k)[3]);
    chk("accept",     accept,     exp_acc);
    chk("out_valid",  out_valid,  o[3]);
    chk("out_sof",    out_sof,    o[2]);
    chk("out_eol",    out_eol,    o[1]);
    chk("out_eof",    out_eof,    o[0]);
    chk("frame_done", frame_done, o[3] & o[0]);
    chk("busy",       busy,       m_in_frame || (infl != 0));
    chk("inflight",   inflight,   infl);
    chk("err_sof",    err_sof,    m_err);
`ifdef FRAME_STATS_EN
    chk("frame_cnt",  frame_cnt,  m_frame_cnt);
    chk("line_cnt",   line_cnt,   m_line_cnt);
`else
    chk("frame_cnt",  frame_cnt,  0);
    chk("line_cnt",   line_cnt,   0);
`endif
    hist[cyc] = {exp_acc, exp_acc & s, exp_acc & l, exp_acc & f};
    if (v && s && m_in_frame) m_err = 1'b1;
    if (exp_acc) m_in_frame = !f;
    if (o[3] && o[0]) m_frame_cnt = (m_frame_cnt + 1) % (1 << CNT_W);
    if (o[3] && o[2]) m_line_cnt = o[1] ? 1 : 0;
    else if (o[3] && o[1]) m_line_cnt = (m_line_cnt + 1) % (1 << CNT_W);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(e, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_inflight"},  inflight,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_err_sof"},   err_sof,   0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("rst0");
    $display("phase reset_init checks=%0d", checks);

    // Non-SOF beats while idle are never admitted.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("phase idle_gating checks=%0d", checks);

    // Eight-beat frame, two lines.
    for (int b = 0; b < 8; b++) cycle(1'b1, 1'b1, b == 0, (b == 3) || (b == 7), b == 7);
    idle(6, 1'b1);
    $display("phase single_frame checks=%0d", checks);

    // Frame B's SOF directly follows frame A's EOF.
    for (int b = 0; b < 4; b++) cycle(1'b1, 1'b1, b == 0, b == 3, b == 3);
    for (int b = 0; b < 5; b++) cycle(1'b1, 1'b1, b == 0, (b == 2) || (b == 4), b == 4);
    idle(6, 1'b1);
    $display("phase back_to_back checks=%0d", checks);

    // en dropped mid-frame and a stray SOF inside the frame.
    for (int b = 0; b < 8; b++) cycle(b < 2, 1'b1, (b == 0) || (b == 4), b == 7, b == 7);
    idle(6, 1'b0);
    $display("phase en_drop_err checks=%0d", checks);

    // Reset in the middle of a frame that already raised err_sof.
    for (int b = 0; b < 3; b++) cycle(1'b1, 1'b1, (b == 0) || (b == 2), 1'b0, 1'b0);
    do_reset("rst_mid");
    for (int b = 0; b < 6; b++) cycle(1'b1, 1'b1, 1'b0, b == 3, b == 5);
    $display("phase reset_mid_frame checks=%0d", checks);

    // Single-beat frame carrying every marker.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(6, 1'b1);
    $display("phase one_beat checks=%0d", checks);

    // Randomized traffic with protocol noise.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 11) == 0);
      if (i == 1500) do_reset("rst_rand");
    end
    idle(8, 1'b0);
    $display("phase random checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
